// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: conditions a raw asynchronous input into a clean,
// debounced level with one-cycle rise/fall pulses.
//   raw_in -> 2-FF synchroniser -> stability filter (N cycles) -> level/pulses
// N is derived from DEBOUNCE_PERIOD / CYCLE_TIME (both in ns), rounded down
// (ROUND_MODE=0) or up (ROUND_MODE=1), with a floor of 1.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add an 8-bit saturating
// glitch_count output that counts aborted waits (bounces).
// There is no valid/ready handshake: raw_in is a free-running level and the
// pulses are fire-and-forget strobes for the downstream timer.
module debounce_edge_detect #(
  parameter int DEBOUNCE_PERIOD = 1000,
  parameter int CYCLE_TIME      = 10,
  parameter int ROUND_MODE      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_in,
  output logic       level,
  output logic       rise_pulse,
  output logic       fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int N_RAW = (ROUND_MODE != 0) ?
                         (DEBOUNCE_PERIOD + CYCLE_TIME - 1) / CYCLE_TIME :
                         DEBOUNCE_PERIOD / CYCLE_TIME;
  localparam int N  = (N_RAW < 1) ? 1 : N_RAW;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          sync1, sync2;
  logic          level_d, rise_d, fall_d;
  logic          abort;

  // Two-stage synchroniser; only sync2 is allowed to reach the filter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // State, counter and registered outputs; pulses come from next-state logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      level      <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  // Stability filter: a level change is accepted only after N consecutive
  // agreeing sync2 samples; any disagreement returns to the idle state.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (sync2) begin
          if (N == 1) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
            state_d = IDLE_HIGH;
          end else begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE_HIGH;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          if (N == 1) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
            state_d = IDLE_LOW;
          end else begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // Count aborted waits (bounces), saturating so it never wraps to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glitch_count <= 8'd0;
    end else if (abort && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect: directed bench for debounce_edge_detect.
// Four instances run side by side on shared raw_in/rst_n:
//   [0] 50ns/10ns round-down -> N=5
//   [1] 55ns/10ns round-up   -> N=6
//   [2] 55ns/10ns round-down -> N=5
//   [3] 0ns                  -> N=1
// With raw_in first sampled at edge E0, level and the pulse land after E(N+1).
// Define DEBOUNCE_GLITCH_CNT_EN to also check glitch_count.
module tb_debounce_edge_detect;

  logic       clk;
  logic       rst_n;
  logic       raw_in;
  logic [3:0] lv;
  logic [3:0] rs;
  logic [3:0] fl;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gc [4];
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int nn [4] = '{5, 6, 5, 1};

  logic [2:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  debounce_edge_detect #(.DEBOUNCE_PERIOD(50), .CYCLE_TIME(10), .ROUND_MODE(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .level(lv[0]), .rise_pulse(rs[0]), .fall_pulse(fl[0])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc[0])
`endif
  );
  debounce_edge_detect #(.DEBOUNCE_PERIOD(55), .CYCLE_TIME(10), .ROUND_MODE(1)) u_n6 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .level(lv[1]), .rise_pulse(rs[1]), .fall_pulse(fl[1])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc[1])
`endif
  );
  debounce_edge_detect #(.DEBOUNCE_PERIOD(55), .CYCLE_TIME(10), .ROUND_MODE(0)) u_n5b (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .level(lv[2]), .rise_pulse(rs[2]), .fall_pulse(fl[2])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc[2])
`endif
  );
  debounce_edge_detect #(.DEBOUNCE_PERIOD(0), .CYCLE_TIME(10), .ROUND_MODE(0)) u_n1 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .level(lv[3]), .rise_pulse(rs[3]), .fall_pulse(fl[3])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc[3])
`endif
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Apply raw_in before the next rising edge, then return at the following
  // falling edge so outputs are sampled mid-cycle.
  task automatic step(input logic r);
    raw_in = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks every instance after edge k of a held transition.
  // rising=1: level goes 0->1 with rise_pulse at k==N+1; else the mirror.
  task automatic check_edge(input string name, input int k, input bit rising);
    for (int d = 0; d < 4; d++) begin
      bit done;
      done = (k >= nn[d] + 1);
      check_val($sformatf("%s_lvl_d%0d_k%0d", name, d, k), {7'd0, lv[d]},
                {7'd0, rising ? done : !done});
      check_val($sformatf("%s_rise_d%0d_k%0d", name, d, k), {7'd0, rs[d]},
                {7'd0, rising && (k == nn[d] + 1)});
      check_val($sformatf("%s_fall_d%0d_k%0d", name, d, k), {7'd0, fl[d]},
                {7'd0, !rising && (k == nn[d] + 1)});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    raw_in = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset state.
    check_val("rst_level", {4'd0, lv}, 8'h00);
    check_val("rst_rise",  {4'd0, rs}, 8'h00);
    check_val("rst_fall",  {4'd0, fl}, 8'h00);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    for (int d = 0; d < 4; d++) check_val($sformatf("rst_gc_d%0d", d), gc[d], 8'd0);
`endif

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check_val($sformatf("idle_level_%0d", i), {4'd0, lv}, 8'h00);
    end

    // Clean rising edge held high.
    for (int k = 0; k <= 9; k++) begin
      step(1'b1);
      check_edge("rise", k, 1'b1);
    end

    // Clean falling edge held low.
    for (int k = 0; k <= 9; k++) begin
      step(1'b0);
      check_edge("fall", k, 1'b0);
    end

    // Bounce: high 3 samples (E0-E2), low 2 (E3-E4), high from E5.
    // N=5 instances settle after E11, N=6 after E12. The N=1 instance follows
    // every change: rise E2, fall E5, rise E7.
    exp_q = '{3'b000, 3'b000, 3'b110, 3'b100, 3'b100, 3'b001, 3'b000,
              3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    for (int k = 0; k <= 13; k++) begin
      logic [2:0] e1;
      step((k < 3) || (k >= 5));
      for (int d = 0; d < 3; d++) begin
        int at;
        at = nn[d] + 6;
        check_val($sformatf("bnc_lvl_d%0d_k%0d", d, k), {7'd0, lv[d]}, {7'd0, k >= at});
        check_val($sformatf("bnc_rise_d%0d_k%0d", d, k), {7'd0, rs[d]}, {7'd0, k == at});
        check_val($sformatf("bnc_fall_d%0d_k%0d", d, k), {7'd0, fl[d]}, 8'd0);
      end
      e1 = exp_q.pop_front();
      check_val($sformatf("bnc_n1_k%0d", k), {5'd0, lv[3], rs[3], fl[3]}, {5'd0, e1});
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check_val("bnc_gc_n5",  gc[0], 8'd1);
    check_val("bnc_gc_n6",  gc[1], 8'd1);
    check_val("bnc_gc_n5b", gc[2], 8'd1);
    check_val("bnc_gc_n1",  gc[3], 8'd0);
`endif

    // Return low and settle.
    for (int k = 0; k <= 9; k++) step(1'b0);
    check_val("settle_low", {4'd0, lv}, 8'h00);

    // Reset two cycles into WAIT_HIGH (E0,E1 sync; E2 enters wait; E3 cnt=2).
    for (int k = 0; k <= 3; k++) step(1'b1);
    check_val("prerst_lvl_n5", {7'd0, lv[0]}, 8'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      check_val($sformatf("inrst_lvl_%0d", i), {4'd0, lv}, 8'h00);
      check_val($sformatf("inrst_rise_%0d", i), {4'd0, rs}, 8'h00);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check_val("inrst_gc_n5", gc[0], 8'd0);
`endif
    // Released with raw_in still high: normal debounce from the release edge.
    rst_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step(1'b1);
      check_edge("rel", k, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
